// File: rtl/cpu_wb_arbiter_if.sv
// Writeback bus bundle: ALU writeback, multiplier result path, hazard query and
// register-bank write port, as seen by the writeback arbiter.
interface cpu_wb_arbiter_if #(
  parameter int REG_WIDTH  = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  alu_wb_valid;
  logic [REG_ADDR_W-1:0] alu_wb_reg;
  logic [REG_WIDTH-1:0]  alu_wb_data;
  logic                  alu_stall;
  logic                  mul_wb_valid;
  logic                  mul_wb_ready;
  logic [REG_ADDR_W-1:0] mul_wb_reg;
  logic [REG_WIDTH-1:0]  mul_wb_data;
  logic [REG_ADDR_W-1:0] query_reg;
  logic                  query_hit;
  logic                  mul_pending;
  logic                  rf_write_enable;
  logic [REG_ADDR_W-1:0] rf_write_reg;
  logic [REG_WIDTH-1:0]  rf_write_data;

  modport master (
    output alu_wb_valid, alu_wb_reg, alu_wb_data,
    output mul_wb_valid, mul_wb_reg, mul_wb_data,
    output query_reg,
    input  alu_stall, mul_wb_ready, query_hit, mul_pending,
    input  rf_write_enable, rf_write_reg, rf_write_data
  );

  modport slave (
    input  alu_wb_valid, alu_wb_reg, alu_wb_data,
    input  mul_wb_valid, mul_wb_reg, mul_wb_data,
    input  query_reg,
    output alu_stall, mul_wb_ready, query_hit, mul_pending,
    output rf_write_enable, rf_write_reg, rf_write_data
  );
endinterface

// File: rtl/cpu_wb_arbiter.sv
// Arbitrates the register bank's primary write port between ALU writeback and a
// small FIFO of multiplier results, with ALU priority, starvation bound and WAW kill.
module cpu_wb_arbiter #(
  parameter int REG_WIDTH      = 32,
  parameter int REG_ADDR_W     = 5,
  parameter int MUL_FIFO_DEPTH = 2,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic              clock,
  input  logic              reset,
  cpu_wb_arbiter_if.slave   bus
);
  localparam int PW = $clog2(MUL_FIFO_DEPTH);
  localparam int CW = $clog2(MUL_FIFO_DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(MUL_FIFO_DEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [PW-1:0]             wr_ptr;
  logic [PW-1:0]             rd_ptr;
  logic [CW-1:0]             count;
  logic [MUL_FIFO_DEPTH-1:0] live;
  logic [REG_ADDR_W-1:0]     ent_reg  [MUL_FIFO_DEPTH];
  logic [REG_WIDTH-1:0]      ent_data [MUL_FIFO_DEPTH];
  logic [SW-1:0]             starve_cnt;

  logic pending;
  logic full;
  logic push;
  logic force_mul;
  logic grant_alu;
  logic pop;
  logic hit;

  assign pending   = (count != '0);
  assign full      = (count == FULL_CNT);
  assign push      = bus.mul_wb_valid & ~full;
  assign force_mul = (starve_cnt == STARVE_MAX) & pending;
  assign grant_alu = bus.alu_wb_valid & ~force_mul;
  assign pop       = ~grant_alu & pending;

  assign bus.alu_stall    = bus.alu_wb_valid & ~grant_alu;
  assign bus.mul_wb_ready = ~full;
  assign bus.mul_pending  = pending;
  assign bus.query_hit    = hit;

  // Live bits are cleared on pop, so only occupied slots can ever report a hit.
  always_comb begin
    hit = 1'b0;
    for (int unsigned i = 0; i < MUL_FIFO_DEPTH; i++) begin
      if (live[PW'(i)] && (ent_reg[PW'(i)] == bus.query_reg)) hit = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      ent_reg[wr_ptr]  <= bus.mul_wb_reg;
      ent_data[wr_ptr] <= bus.mul_wb_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      count               <= '0;
      live                <= '0;
      starve_cnt          <= '0;
      bus.rf_write_enable <= 1'b0;
      bus.rf_write_reg    <= '0;
      bus.rf_write_data   <= '0;
    end else begin
      if (grant_alu) begin
        for (int unsigned i = 0; i < MUL_FIFO_DEPTH; i++) begin
          if (ent_reg[PW'(i)] == bus.alu_wb_reg) live[PW'(i)] <= 1'b0;
        end
      end
      if (pop) begin
        live[rd_ptr] <= 1'b0;
        rd_ptr       <= rd_ptr + PW'(1);
      end
      // The enqueue slot is never occupied, so this overrides any kill above.
      if (push) begin
        live[wr_ptr] <= 1'b1;
        wr_ptr       <= wr_ptr + PW'(1);
      end

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (pop || !pending)
        starve_cnt <= '0;
      else if (grant_alu && (starve_cnt != STARVE_MAX))
        starve_cnt <= starve_cnt + SW'(1);

      if (grant_alu) begin
        bus.rf_write_enable <= 1'b1;
        bus.rf_write_reg    <= bus.alu_wb_reg;
        bus.rf_write_data   <= bus.alu_wb_data;
      end else if (pop && live[rd_ptr]) begin
        bus.rf_write_enable <= 1'b1;
        bus.rf_write_reg    <= ent_reg[rd_ptr];
        bus.rf_write_data   <= ent_data[rd_ptr];
      end else begin
        bus.rf_write_enable <= 1'b0;
      end
    end
  end
endmodule
